// File: rtl/mem_copy_engine.sv
// Block-copy engine driving the word-addressed data-memory port.
// Ports: clk, reset(n), start/src_adr/dst_adr/count in; busy/done/err and memory-port outputs.
module mem_copy_engine #(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [31:0]     src_adr,
  input  logic [31:0]     dst_adr,
  input  logic [CNTW-1:0] count,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            memwrite,
  output logic [31:0]     dataadr,
  output logic [31:0]     writedata,
  input  logic [31:0]     readdata
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    FIN
  } state_t;

  state_t          state;
  logic [31:0]     src;
  logic [31:0]     dst;
  logic [CNTW-1:0] remaining;
  logic            misaligned;

  assign misaligned = (src_adr[1:0] != 2'b00) ||
                      (dst_adr[1:0] != 2'b00);

  // Outputs are loaded for the state being entered, so they are
  // registered and already valid during that state's cycle.
  // writedata doubles as the read buffer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      memwrite  <= 1'b0;
      dataadr   <= '0;
      writedata <= '0;
      src       <= '0;
      dst       <= '0;
      remaining <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (misaligned) begin
              err <= 1'b1;
            end else if (count == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              src       <= src_adr;
              dst       <= dst_adr;
              remaining <= count;
              state     <= RD;
              busy      <= 1'b1;
              dataadr   <= src_adr;
            end
          end
        end
        RD: begin
          writedata <= readdata;
          dataadr   <= dst;
          memwrite  <= 1'b1;
          state     <= WR;
        end
        WR: begin
          src       <= src + 32'd4;
          dst       <= dst + 32'd4;
          remaining <= remaining - 1'b1;
          memwrite  <= 1'b0;
          if (remaining == 1) begin
            state   <= FIN;
            done    <= 1'b1;
            busy    <= 1'b0;
            dataadr <= '0;
          end else begin
            state   <= RD;
            dataadr <= src + 32'd4;
          end
        end
        FIN: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a 256-word RAM model.
// Monitor counts writes/busy/done cycles and logs read addresses.
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] src_adr;
  logic [31:0] dst_adr;
  logic [15:0] count;
  logic        busy;
  logic        done;
  logic        err;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;

  logic [31:0] ram [0:255];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          wr_cnt, busy_cnt, done_cnt, err_cnt, bad_wr;
  logic [31:0] rd_log [$];
  int          lat;

  mem_copy_engine #(.CNTW(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .src_adr   (src_adr),
    .dst_adr   (dst_adr),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .readdata  (readdata)
  );

  always #5 clk = ~clk;

  assign readdata = ram[dataadr[9:2]];

  always @(posedge clk)
    if (memwrite) ram[dataadr[9:2]] <= writedata;

  always @(negedge clk) begin
    if (memwrite) wr_cnt++;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (memwrite && !busy) bad_wr++;
    if (busy && !memwrite) rd_log.push_back(dataadr);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr();
    wr_cnt = 0; busy_cnt = 0; done_cnt = 0; err_cnt = 0;
    rd_log.delete();
  endtask

  // Returns at the negedge of the first cycle after the accepting edge.
  task automatic start_copy(input logic [31:0] s,
                            input logic [31:0] d,
                            input logic [15:0] c);
    @(negedge clk);
    src_adr = s; dst_adr = d; count = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int first, output int l);
    l = first;
    while (!done && l < 200) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    bad_wr = 0;
    reset = 1'b0; start = 1'b0;
    src_adr = '0; dst_adr = '0; count = '0;
    clr();
    idle(2);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_memwrite", {31'b0, memwrite}, 32'd0);
    check("rst_dataadr", dataadr, 32'd0);
    check("rst_writedata", writedata, 32'd0);
    reset = 1'b1;
    idle(1);

    // 1: basic 4-word copy
    for (int i = 0; i < 4; i++) ram[i] = 32'hA000_0000 + i;
    clr();
    start_copy(32'h0, 32'h40, 16'd4);
    wait_done(1, lat);
    check("t1_latency", lat, 32'd9);
    idle(2);
    for (int i = 0; i < 4; i++)
      check("t1_data", ram[16+i], 32'hA000_0000 + i);
    check("t1_writes", wr_cnt, 32'd4);
    check("t1_busy_cycles", busy_cnt, 32'd8);
    check("t1_done_pulses", done_cnt, 32'd1);

    // 2: zero-length copy
    clr();
    start_copy(32'h0, 32'h40, 16'd0);
    wait_done(1, lat);
    check("t2_latency", lat, 32'd1);
    idle(3);
    check("t2_writes", wr_cnt, 32'd0);
    check("t2_busy", busy_cnt, 32'd0);
    check("t2_done_pulses", done_cnt, 32'd1);

    // 3: misaligned source rejected, then aligned retry
    clr();
    start_copy(32'h2, 32'h80, 16'd1);
    check("t3_err", {31'b0, err}, 32'd1);
    check("t3_busy", {31'b0, busy}, 32'd0);
    idle(1);
    check("t3_err_pulse", {31'b0, err}, 32'd0);
    idle(2);
    check("t3_err_count", err_cnt, 32'd1);
    check("t3_no_access", wr_cnt + busy_cnt, 32'd0);
    check("t3_no_done", done_cnt, 32'd0);
    start_copy(32'h4, 32'h80, 16'd1);
    wait_done(1, lat);
    check("t3_retry_latency", lat, 32'd3);
    idle(1);
    check("t3_retry_data", ram[32], ram[1]);
    check("t3_retry_val", ram[32], 32'hA000_0001);

    // 4: reset during the second WR
    for (int i = 0; i < 4; i++) begin
      ram[i]    = 32'hB000_0000 + i;
      ram[16+i] = 32'hC000_0000 + i;
    end
    clr();
    start_copy(32'h0, 32'h40, 16'd4);
    idle(3);
    check("t4_in_wr", {31'b0, memwrite}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("t4_busy", {31'b0, busy}, 32'd0);
    check("t4_memwrite", {31'b0, memwrite}, 32'd0);
    check("t4_dataadr", dataadr, 32'd0);
    check("t4_writedata", writedata, 32'd0);
    reset = 1'b1;
    idle(12);
    check("t4_ram16", ram[16], 32'hB000_0000);
    check("t4_ram17", ram[17], 32'hB000_0001);
    check("t4_ram18", ram[18], 32'hC000_0002);
    check("t4_ram19", ram[19], 32'hC000_0003);
    check("t4_no_done", done_cnt, 32'd0);
    check("t4_writes", wr_cnt, 32'd2);

    // 5: start while busy is ignored
    for (int i = 0; i < 3; i++) ram[64+i] = 32'hD000_0000 + i;
    for (int i = 0; i < 5; i++) ram[128+i] = 32'hEEEE_0000 + i;
    clr();
    start_copy(32'h100, 32'h180, 16'd3);
    src_adr = 32'h10; dst_adr = 32'h200; count = 16'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2, lat);
    check("t5_latency", lat, 32'd7);
    idle(4);
    for (int i = 0; i < 3; i++)
      check("t5_data", ram[96+i], 32'hD000_0000 + i);
    check("t5_other_dst", ram[128], 32'hEEEE_0000);
    check("t5_writes", wr_cnt, 32'd3);
    check("t5_done_pulses", done_cnt, 32'd1);

    // 6: source address wraps past 0xFFFFFFFC
    ram[254] = 32'h1111_0000;
    ram[255] = 32'h2222_0000;
    ram[0]   = 32'h3333_0000;
    clr();
    start_copy(32'hFFFF_FFF8, 32'h300, 16'd3);
    wait_done(1, lat);
    check("t6_latency", lat, 32'd7);
    idle(1);
    check("t6_reads", rd_log.size(), 32'd3);
    if (rd_log.size() == 3) begin
      check("t6_rd0", rd_log[0], 32'hFFFF_FFF8);
      check("t6_rd1", rd_log[1], 32'hFFFF_FFFC);
      check("t6_rd2", rd_log[2], 32'h0000_0000);
    end
    check("t6_d0", ram[192], 32'h1111_0000);
    check("t6_d1", ram[193], 32'h2222_0000);
    check("t6_d2", ram[194], 32'h3333_0000);

    check("memwrite_only_busy", bad_wr, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
